// File: rtl/sum_of_squares_if.sv
// sum_of_squares_if: request/result bundle for the sum_of_squares unit.
//   start    request strobe (sampled only while the unit is idle)
//   x_in     signed fixed-point operand
//   y_in     signed fixed-point operand
//   busy     computation in flight
//   done     one-cycle result strobe
//   sum_out  unsigned x^2+y^2, held until the next done
//   overflow result saturated, held with sum_out
// master = requester side, slave = the unit.
interface sum_of_squares_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] y_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             overflow;

  modport master (
    output start, x_in, y_in,
    input  busy, done, sum_out, overflow
  );

  modport slave (
    input  start, x_in, y_in,
    output busy, done, sum_out, overflow
  );
endinterface

// File: rtl/sum_of_squares.sv
// sum_of_squares: sequential x^2 + y^2 on signed fixed-point operands,
// producing the unsigned fixed-point value fed to the sqrt block.
// Squaring is shift-add, one multiplier bit per clock: WIDTH cycles for |x|,
// WIDTH cycles for |y| into a shared accumulator, then one finishing cycle
// that truncates away FRAC_WIDTH bits and saturates to WIDTH bits.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   sum_of_squares_if.slave (start/x_in/y_in in, busy/done/sum_out/overflow out)
// FRAC_WIDTH must be even and less than WIDTH so the squared format lines
// back up with the operand format after the shift.
module sum_of_squares #(
  parameter int WIDTH      = 32,
  parameter int FRAC_WIDTH = 30
) (
  input logic          clk,
  input logic          rst,
  sum_of_squares_if.slave bus
);

  localparam int ACC_W = 2*WIDTH + 1;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SQX, SQY, FIN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mag_y_q;   // |y| parked until the SQY pass
  logic [WIDTH-1:0]   mplier_q;  // multiplier, shifted right: bit 0 == bit[count]
  logic [2*WIDTH-1:0] mcand_q;   // multiplicand, shifted left: == |v| << count
  logic [ACC_W-1:0]   acc_q;
  logic               busy_q, done_q, ovf_q;
  logic [WIDTH-1:0]   sum_q;

  logic [WIDTH-1:0]   mag_x, mag_y;
  logic               last_bit;
  logic [ACC_W-1:0]   acc_step;
  logic [ACC_W-1:0]   res_full;
  logic               sat;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1),
  // which is still exact as an unsigned WIDTH-bit number.
  assign mag_x = bus.x_in[WIDTH-1] ? (~bus.x_in + WIDTH'(1)) : bus.x_in;
  assign mag_y = bus.y_in[WIDTH-1] ? (~bus.y_in + WIDTH'(1)) : bus.y_in;

  assign last_bit = (cnt_q == CNT_W'(WIDTH-1));
  assign acc_step = mplier_q[0] ? (acc_q + {1'b0, mcand_q}) : acc_q;

  // Back to operand format; anything at or above bit WIDTH means saturation.
  assign res_full = acc_q >> FRAC_WIDTH;
  assign sat      = |res_full[ACC_W-1:WIDTH];

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SQX;
      SQX:     if (last_bit)  state_d = SQY;
      SQY:     if (last_bit)  state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      mag_y_q  <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      sum_q    <= '0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mag_y_q  <= mag_y;
            mplier_q <= mag_x;
            mcand_q  <= {{WIDTH{1'b0}}, mag_x};
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        SQX: begin
          acc_q <= acc_step;
          if (last_bit) begin
            // hand the shared shift-add engine over to |y|
            cnt_q    <= '0;
            mplier_q <= mag_y_q;
            mcand_q  <= {{WIDTH{1'b0}}, mag_y_q};
          end else begin
            cnt_q    <= cnt_q + CNT_W'(1);
            mplier_q <= mplier_q >> 1;
            mcand_q  <= mcand_q << 1;
          end
        end
        SQY: begin
          acc_q <= acc_step;
          if (last_bit) begin
            cnt_q <= '0;
          end else begin
            cnt_q    <= cnt_q + CNT_W'(1);
            mplier_q <= mplier_q >> 1;
            mcand_q  <= mcand_q << 1;
          end
        end
        FIN: begin
          sum_q  <= sat ? {WIDTH{1'b1}} : res_full[WIDTH-1:0];
          ovf_q  <= sat;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum_out  = sum_q;
  assign bus.overflow = ovf_q;

endmodule

// File: doc/sum_of_squares.md
# sum_of_squares

Sequential fixed-point sum-of-squares unit: computes x² + y² for a signed 2D vector, such as a ball velocity or separation, and presents the result in the unsigned fixed-point format consumed by the `sqrt` block's `num_in`. It is the producing end of the vector-length path (`sum_of_squares` → `sqrt`) used for collision distance and speed normalisation. Multiplication is shift-add, one bit per clock, to keep area small.

## Interface
- `WIDTH`, 32, operand and result width in bits.
- `FRAC_WIDTH`, 30, fractional bits of operands and result; must be even and less than `WIDTH`.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled only in IDLE.
- `x_in`  input  WIDTH  signed two's-complement fixed point, FRAC_WIDTH fractional bits.
- `y_in`  input  WIDTH  same format as `x_in`.
- `busy`  output  1  high while a computation is in flight.
- `done`  output  1  one-cycle pulse; `sum_out` is valid from this cycle.
- `sum_out`  output  WIDTH  unsigned x²+y², FRAC_WIDTH fractional bits; held until the next `done`.
- `overflow`  output  1  set with `done` when the result saturated; held with `sum_out`.

## Operation
- States: IDLE, SQX, SQY, FIN.
- IDLE:
  - When `start` = 1 at an edge, latch |x_in| and |y_in| as WIDTH-bit unsigned magnitudes.
  - Clear the 2·WIDTH+1-bit accumulator, clear the bit counter, and go to SQX.
  - `x_in`/`y_in` are don't-care after the start edge.
- Magnitudes: |−2^(WIDTH−1)| = 2^(WIDTH−1) is representable unsigned; no special case.
- SQX:
  - Each cycle, if bit[count] of |x| = 1, acc += |x| << count; then count++.
  - After WIDTH cycles, clear count and go to SQY.
- SQY: same algorithm on |y|, adding into the same accumulator. After WIDTH cycles, go to FIN.
- FIN:
  - Compute r = acc >> FRAC_WIDTH (truncate, no rounding).
  - If r ≥ 2^WIDTH: `sum_out` = all ones, `overflow` = 1. Otherwise `sum_out` = r[WIDTH−1:0], `overflow` = 0.
  - Pulse `done` and return to IDLE.
- `start` outside IDLE (including the FIN cycle) is ignored. It is not queued.
- Reset (asynchronous, any time, including mid-computation):
  - State returns to IDLE; accumulator and counter clear.
  - `busy` = 0, `done` = 0, `sum_out` = 0, `overflow` = 0.
  - No `done` is produced for the aborted request.

## Timing
- Let E0 be the edge that samples `start` in IDLE.
- `busy` rises after E0 and falls after E0+2·WIDTH+1.
- `done` is high for exactly the cycle between E0+2·WIDTH+1 and E0+2·WIDTH+2. That is 65 edges for WIDTH = 32.
- `sum_out` and `overflow` update at the same edge `done` rises.
- Earliest next start edge is E0+2·WIDTH+2 (back-to-back throughput: one result per 2·WIDTH+2 cycles).
- `done` and `busy` are never high in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Basic and zero operand, WIDTH = 32, FRAC_WIDTH = 30:
  - x = 0x40000000 (1.0), y = 0 → `sum_out` = 0x40000000, `overflow` = 0.
  - `done` appears exactly 65 edges after start.
- Sign handling:
  - x = 0xC0000000 (−1.0), y = 0x40000000 → `sum_out` = 0x80000000 (2.0).
  - x = y = 0x20000000 (0.5) → `sum_out` = 0x20000000.
- Saturation:
  - x = y = 0x80000000 (−2.0, true sum 8.0) → `sum_out` = 0xFFFFFFFF, `overflow` = 1.
  - x = 0x60000000 (1.5), y = 0 → 0x90000000, `overflow` = 0.
- Truncation: x = 0x00000001, y = 0x00000001 → `sum_out` = 0x00000000, `overflow` = 0.
- Handshake:
  - Hold `start` high continuously. Results arrive every 66 cycles, and no second `done` occurs within a computation.
  - A start pulse during SQY is ignored; `sum_out` matches the first operands.
- Reset mid-operation:
  - Assert `rst` low for 1 cycle at cycle 20 of a computation. `busy`/`done`/`sum_out`/`overflow` immediately read 0.
  - No `done` follows. A fresh start then yields the correct result at 65 edges.
